// File: rtl/dm_pkg.sv
// dm_pkg: shared encodings for the data-memory responder.
// Size codes, FSM states and wait-counter width.
package dm_pkg;

   localparam int WAIT_W = 4;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ACCESS,
      ST_RESP
   } state_e;

endpackage

// File: rtl/dm_lane.sv
// dm_lane: little-endian lane merge for stores, lane extract and
// extension for loads, plus alignment check.
module dm_lane
   import dm_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  a_lo,
   input  logic        sign,
   input  logic [31:0] old_word,
   input  logic [31:0] wdata,
   output logic [31:0] st_word,
   output logic [31:0] ld_val,
   output logic        misalign
);

   logic [4:0]  shamt;
   logic [31:0] lane;

   // Merge store data into its lane and extract/extend the load lane.
   always_comb begin
      st_word  = old_word;
      ld_val   = 32'd0;
      misalign = 1'b0;
      shamt    = 5'd0;
      lane     = 32'd0;
      case (size)
         SZ_BYTE: begin
            shamt   = {a_lo, 3'b000};
            st_word = (old_word & ~(32'h0000_00ff << shamt))
                    | ({24'd0, wdata[7:0]} << shamt);
            lane    = old_word >> shamt;
            ld_val  = sign ? {{24{lane[7]}}, lane[7:0]}
                           : {24'd0, lane[7:0]};
         end
         SZ_HALF: begin
            misalign = a_lo[0];
            shamt    = {a_lo[1], 4'b0000};
            st_word  = (old_word & ~(32'h0000_ffff << shamt))
                     | ({16'd0, wdata[15:0]} << shamt);
            lane     = old_word >> shamt;
            ld_val   = sign ? {{16{lane[15]}}, lane[15:0]}
                            : {16'd0, lane[15:0]};
         end
         SZ_WORD: begin
            misalign = (a_lo != 2'b00);
            st_word  = wdata;
            ld_val   = old_word;
         end
         default: begin
            misalign = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/dm_responder.sv
// dm_responder: multi-cycle data-memory responder with programmable
// wait states, registered ready/rdata/err and a word array.
module dm_responder
   import dm_pkg::*;
#(
   parameter int DEPTH_LOG2  = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic        sign,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        ready,
   output logic [31:0] rdata,
   output logic        err,
   output logic        busy
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_CYCLES);

   state_e            state_q, state_d;
   logic [WAIT_W-1:0] cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [1:0]        size_q, size_d;
   logic              sign_q, sign_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              ready_q, ready_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              busy_q, busy_d;

   logic [31:0]           mem [DEPTH];
   logic [DEPTH_LOG2-1:0] idx;
   logic [31:0]           rd_word;
   logic [31:0]           st_word;
   logic [31:0]           ld_val;
   logic                  misalign;
   logic                  bad;
   logic                  mem_we;

   assign idx     = addr_q[DEPTH_LOG2+1:2];
   assign rd_word = mem[idx];

   dm_lane u_lane (
      .size     (size_q),
      .a_lo     (addr_q[1:0]),
      .sign     (sign_q),
      .old_word (rd_word),
      .wdata    (wdata_q),
      .st_word  (st_word),
      .ld_val   (ld_val),
      .misalign (misalign)
   );

   assign bad = (size_q == SZ_ILL) | misalign
              | ((addr_q >> (DEPTH_LOG2 + 2)) != 32'd0);

   // Next-state, capture and response computation.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      size_d  = size_q;
      sign_d  = sign_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      ready_d = 1'b0;
      rdata_d = rdata_q;
      err_d   = err_q;
      mem_we  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            rdata_d = 32'd0;
            err_d   = 1'b0;
            if (req) begin
               we_d    = we;
               size_d  = size;
               sign_d  = sign;
               addr_d  = addr;
               wdata_d = wdata;
               cnt_d   = WAIT_INIT;
               state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - 1'b1;
            if (bad) begin
               state_d = ST_RESP;
               ready_d = 1'b1;
               err_d   = 1'b1;
               rdata_d = 32'd0;
            end else if (cnt_q == 1) begin
               state_d = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            state_d = ST_RESP;
            ready_d = 1'b1;
            if (bad) begin
               err_d   = 1'b1;
               rdata_d = 32'd0;
            end else if (we_q) begin
               mem_we  = 1'b1;
               rdata_d = 32'd0;
            end else begin
               rdata_d = ld_val;
            end
         end
         default: begin
            state_d = ST_IDLE;
            rdata_d = 32'd0;
            err_d   = 1'b0;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // Control state and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         size_q  <= SZ_BYTE;
         sign_q  <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         ready_q <= 1'b0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         size_q  <= size_d;
         sign_q  <= sign_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         ready_q <= ready_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
      end
   end

   // Word array write; contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[idx] <= st_word;
      end
   end

   assign ready = ready_q;
   assign rdata = rdata_q;
   assign err   = err_q;
   assign busy  = busy_q;

endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: directed checks of dm_responder with 2 and 0
// wait states, lane handling, errors, busy and reset behaviour.
module tb_dm_responder;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req0 = 1'b0;
   logic        req1 = 1'b0;
   logic        we = 1'b0;
   logic [1:0]  size = 2'b00;
   logic        sign = 1'b0;
   logic [31:0] addr = 32'd0;
   logic [31:0] wdata = 32'd0;

   logic        ready0, err0, busy0;
   logic [31:0] rdata0;
   logic        ready1, err1, busy1;
   logic [31:0] rdata1;

   int errors = 0;
   int checks = 0;
   bit cur = 1'b0;

   always #5 clk = ~clk;

   dm_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(2)) u_dut0 (
      .clk(clk), .reset(reset), .req(req0), .we(we),
      .size(size), .sign(sign), .addr(addr), .wdata(wdata),
      .ready(ready0), .rdata(rdata0), .err(err0), .busy(busy0)
   );

   dm_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_dut1 (
      .clk(clk), .reset(reset), .req(req1), .we(we),
      .size(size), .sign(sign), .addr(addr), .wdata(wdata),
      .ready(ready1), .rdata(rdata1), .err(err1), .busy(busy1)
   );

   logic        rdy_m, err_m, busy_m;
   logic [31:0] rd_m;
   assign rdy_m  = cur ? ready1 : ready0;
   assign err_m  = cur ? err1   : err0;
   assign busy_m = cur ? busy1  : busy0;
   assign rd_m   = cur ? rdata1 : rdata0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_req(input bit sel, input bit w,
                         input logic [1:0] sz, input bit sg,
                         input logic [31:0] a, input logic [31:0] d,
                         input int lat, input logic [31:0] exp_rd,
                         input bit exp_err, input string tag);
      int n;
      cur = sel;
      @(negedge clk);
      we = w; size = sz; sign = sg; addr = a; wdata = d;
      if (sel) req1 = 1'b1; else req0 = 1'b1;
      @(posedge clk);
      #1;
      req0 = 1'b0; req1 = 1'b0;
      wdata = 32'hxxxx_xxxx;
      n = 0;
      while (n <= 40) begin
         @(posedge clk);
         #1;
         n++;
         if (rdy_m) break;
      end
      chk({tag, ".lat"}, 32'(n), 32'(lat));
      chk({tag, ".rdata"}, rd_m, exp_rd);
      chk({tag, ".err"}, {31'd0, err_m}, {31'd0, exp_err});
      @(posedge clk);
      #1;
      chk({tag, ".after"}, {rd_m[31:1], rd_m[0] | rdy_m | err_m},
          32'd0);
   endtask

   initial begin
      int n;
      int nrdy;
      #2;
      cur = 1'b0;
      chk("rst.ready0", {31'd0, ready0}, 32'd0);
      chk("rst.busy0", {31'd0, busy0}, 32'd0);
      chk("rst.rdata0", rdata0, 32'd0);
      chk("rst.err1", {31'd0, err1}, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      do_req(0, 1, 2'b10, 0, 32'h10, 32'h1234_5678, 3, 0, 0, "st_w");
      do_req(0, 0, 2'b10, 0, 32'h10, 0, 3, 32'h1234_5678, 0, "ld_w");
      do_req(0, 1, 2'b00, 0, 32'h11, 32'h0000_0080, 3, 0, 0, "st_b");
      do_req(0, 1, 2'b01, 0, 32'h12, 32'h0000_beef, 3, 0, 0, "st_h");
      do_req(0, 0, 2'b10, 0, 32'h10, 0, 3, 32'hbeef_8078, 0, "ld_m");
      do_req(0, 0, 2'b00, 1, 32'h11, 0, 3, 32'hffff_ff80, 0, "ld_bs");
      do_req(0, 0, 2'b00, 0, 32'h11, 0, 3, 32'h0000_0080, 0, "ld_bz");
      do_req(0, 0, 2'b01, 1, 32'h12, 0, 3, 32'hffff_beef, 0, "ld_hs");
      do_req(0, 0, 2'b00, 1, 32'h10, 0, 3, 32'h0000_0078, 0, "ld_b0");

      do_req(0, 1, 2'b10, 0, 32'h0, 32'hcafe_f00d, 3, 0, 0, "st_0");
      do_req(0, 1, 2'b10, 0, 32'h2, 32'hffff_ffff, 1, 0, 1, "e_word");
      do_req(0, 1, 2'b01, 0, 32'h1, 32'hffff_ffff, 1, 0, 1, "e_half");
      do_req(0, 1, 2'b11, 0, 32'h0, 32'hffff_ffff, 1, 0, 1, "e_size");
      do_req(0, 1, 2'b10, 0, 32'h1000, 32'hffff_ffff, 1, 0, 1, "e_rng");
      do_req(0, 0, 2'b10, 0, 32'h1000, 0, 1, 0, 1, "e_ld");
      do_req(0, 0, 2'b10, 0, 32'h0, 0, 3, 32'hcafe_f00d, 0, "ld_0");
      do_req(0, 1, 2'b10, 0, 32'hffc, 32'h0bad_f00d, 3, 0, 0, "st_top");
      do_req(0, 0, 2'b10, 0, 32'hffc, 0, 3, 32'h0bad_f00d, 0, "ld_top");

      cur = 1'b0;
      @(negedge clk);
      we = 1'b0; size = 2'b10; sign = 1'b0; addr = 32'h10;
      req0 = 1'b1;
      @(posedge clk);
      #1;
      we = 1'b1; wdata = 32'hdead_dead; addr = 32'h10;
      n = 0;
      nrdy = 0;
      while (n < 3) begin
         chk("busy.hi", {31'd0, busy0}, 32'd1);
         @(posedge clk);
         #1;
         n++;
         if (ready0) nrdy++;
      end
      req0 = 1'b0;
      chk("busy.rdy", {31'd0, ready0}, 32'd1);
      chk("busy.rd", rdata0, 32'hbeef_8078);
      chk("busy.resp", {31'd0, busy0}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         if (ready0) nrdy++;
      end
      chk("busy.once", 32'(nrdy), 32'd1);
      chk("busy.idle", {31'd0, busy0}, 32'd0);
      do_req(0, 0, 2'b10, 0, 32'h10, 0, 3, 32'hbeef_8078, 0, "busy.ld");

      do_req(1, 1, 2'b10, 0, 32'h40, 32'ha5a5_5a5a, 1, 0, 0, "z_st");
      do_req(1, 0, 2'b10, 0, 32'h40, 0, 1, 32'ha5a5_5a5a, 0, "z_ld");
      do_req(1, 1, 2'b00, 0, 32'h43, 32'h0000_007f, 1, 0, 0, "z_stb");
      do_req(1, 0, 2'b10, 0, 32'h40, 0, 1, 32'h7fa5_5a5a, 0, "z_ldw");
      do_req(1, 0, 2'b01, 1, 32'h42, 0, 1, 32'h0000_7fa5, 0, "z_ldh");
      do_req(1, 1, 2'b01, 0, 32'h41, 32'h1, 1, 0, 1, "z_err");

      do_req(0, 1, 2'b10, 0, 32'h20, 32'h1122_3344, 3, 0, 0, "r_st");
      cur = 1'b0;
      @(negedge clk);
      we = 1'b1; size = 2'b10; addr = 32'h20; wdata = 32'h5566_7788;
      req0 = 1'b1;
      @(posedge clk);
      #1;
      req0 = 1'b0;
      chk("r.busy", {31'd0, busy0}, 32'd1);
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      chk("r.ready", {31'd0, ready0}, 32'd0);
      chk("r.busyl", {31'd0, busy0}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      do_req(0, 0, 2'b10, 0, 32'h20, 0, 3, 32'h1122_3344, 0, "r_ld");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
